// File: rtl/ram_stream_loader_if.sv
// Bus bundle between the operand/result streams, the core's RAM ports and the loader.
// Defining LOADER_LAST_EN adds out_last to the bundle and to both modports.
interface ram_stream_loader_if #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              iram_we;
    logic [ADDR_W-1:0] iram_addr;
    logic [DATA_W-1:0] iram_wdata;
    logic              core_start;
    logic              core_done;
    logic [ADDR_W-1:0] oram_addr;
    logic [RES_W-1:0]  oram_rdata;
    logic              out_valid;
    logic [RES_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
`ifdef LOADER_LAST_EN
    logic              out_last;

    modport master (
        input  in_valid, in_data, core_done, oram_rdata, out_ready,
        output in_ready, iram_we, iram_addr, iram_wdata, core_start,
               oram_addr, out_valid, out_data, busy, out_last
    );
    modport slave (
        output in_valid, in_data, core_done, oram_rdata, out_ready,
        input  in_ready, iram_we, iram_addr, iram_wdata, core_start,
               oram_addr, out_valid, out_data, busy, out_last
    );
`else
    modport master (
        input  in_valid, in_data, core_done, oram_rdata, out_ready,
        output in_ready, iram_we, iram_addr, iram_wdata, core_start,
               oram_addr, out_valid, out_data, busy
    );
    modport slave (
        output in_valid, in_data, core_done, oram_rdata, out_ready,
        input  in_ready, iram_we, iram_addr, iram_wdata, core_start,
               oram_addr, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/ram_stream_loader.sv
// Loads 2*N_PAIRS operand words into the input RAM, kicks the core, then streams N_PAIRS results out.
// Optional out_last flag on the final result is enabled by defining LOADER_LAST_EN.
module ram_stream_loader #(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32,
    parameter int N_PAIRS = 8,
    parameter int ADDR_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_stream_loader_if.master  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_KICK      = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RD_REQ    = 3'd4;
    localparam logic [2:0] S_RD_WAIT   = 3'd5;
    localparam logic [2:0] S_DRAIN     = 3'd6;

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(2*N_PAIRS-1);
    localparam logic [ADDR_W:0] LAST_RES  = (ADDR_W+1)'(N_PAIRS-1);

    logic [2:0]       r_state;
    logic [ADDR_W:0]  r_wcnt;
    logic [ADDR_W:0]  r_rcnt;
    logic [RES_W-1:0] r_out_data;

    logic w_in_ready;
    logic w_accept;

    // Gated by rst so every output reads 0 while reset is held, even in IDLE.
    assign w_in_ready = !rst && ((r_state == S_IDLE) || (r_state == S_FILL));
    assign w_accept   = w_in_ready && bus.in_valid;

    assign bus.in_ready   = w_in_ready;
    assign bus.iram_we    = w_accept;
    assign bus.iram_addr  = r_wcnt[ADDR_W-1:0];
    assign bus.iram_wdata = w_accept ? bus.in_data : '0;
    assign bus.core_start = (r_state == S_KICK);
    assign bus.oram_addr  = r_rcnt[ADDR_W-1:0];
    assign bus.out_valid  = (r_state == S_DRAIN);
    assign bus.out_data   = r_out_data;
    assign bus.busy       = (r_state != S_IDLE);
`ifdef LOADER_LAST_EN
    assign bus.out_last   = (r_state == S_DRAIN) && (r_rcnt == LAST_RES);
`endif

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_FILL: begin
                    if (w_accept) begin
                        r_wcnt  <= r_wcnt + 1'b1;
                        r_state <= (r_wcnt == LAST_WORD) ? S_KICK : S_FILL;
                    end
                end
                S_KICK: begin
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.core_done) begin
                        r_rcnt  <= '0;
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // The output RAM has a one-cycle read latency, so data is valid here.
                    r_out_data <= bus.oram_rdata;
                    r_state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        r_rcnt <= r_rcnt + 1'b1;
                        if (r_rcnt == LAST_RES) begin
                            r_wcnt  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ram_stream_loader.md
Name: ram_stream_loader

Overview:
- Host-side companion to the bit-finding datapath controller.
- Accepts operand words over a valid/ready stream and writes them into the input RAM.
- Issues a one-cycle start to the core, waits for its done pulse, then reads every result from the output RAM and streams it out over a valid/ready interface.
- Sits between the testbench/host and the core's two RAMs.

Parameters:
- DATA_W, 16, operand word width (input RAM data width).
- RES_W, 32, result word width (output RAM data width).
- N_PAIRS, 8, number of operand pairs per job; the job carries 2*N_PAIRS input words and N_PAIRS results.
- ADDR_W, 5, RAM address width; must satisfy 2^ADDR_W >= 2*N_PAIRS.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  host operand word valid.
- in_data  in  DATA_W  host operand word.
- in_ready  out  1  loader accepts in_data this cycle.
- iram_we  out  1  input RAM write enable.
- iram_addr  out  ADDR_W  input RAM write address.
- iram_wdata  out  DATA_W  input RAM write data.
- core_start  out  1  start pulse to the core controller.
- core_done  in  1  one-cycle done pulse from the core.
- oram_addr  out  ADDR_W  output RAM read address.
- oram_rdata  in  RES_W  output RAM read data; synchronous read, valid one cycle after the address.
- out_valid  out  1  result word valid.
- out_data  out  RES_W  result word.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; every output 0; address counters 0; out_data 0.
- Counters:
  - wcnt is ADDR_W+1 bits, counts accepted input words.
  - rcnt is ADDR_W+1 bits, counts emitted results.
- IDLE:
  - in_ready=1.
  - The first in_valid&&in_ready writes word 0, then the FSM goes to FILL.
  - There is no separate go input.
- FILL:
  - in_ready=1.
  - Each accepted word drives iram_we=1, iram_addr=wcnt[ADDR_W-1:0], iram_wdata=in_data in the same cycle (combinational), and increments wcnt.
  - When the accepted word has wcnt==2*N_PAIRS-1, go to KICK.
  - in_valid=0 stalls indefinitely with no write.
- KICK:
  - core_start=1 for exactly one cycle; in_ready=0.
  - Go to WAIT_DONE; core_start is 0 again from that cycle on.
- WAIT_DONE:
  - Wait for core_done=1, then clear rcnt and go to RD_REQ.
  - core_done in any other state is ignored.
- RD_REQ: drive oram_addr=rcnt, go to RD_WAIT.
- RD_WAIT: oram_addr is held; register oram_rdata into out_data at this edge; go to DRAIN.
- DRAIN:
  - out_valid=1; out_data is stable while out_ready=0.
  - On out_ready=1: increment rcnt. If the emitted result was rcnt==N_PAIRS-1, go to IDLE (clearing wcnt); otherwise go to RD_REQ.
- Throughput: 3 cycles per result minimum, no pipelining across results.
- in_ready=0 in KICK, WAIT_DONE, RD_REQ, RD_WAIT and DRAIN. in_valid there is ignored and no RAM write occurs.
- Boundary conditions:
  - Address wrap: wcnt never exceeds 2*N_PAIRS-1 while writing; the next job restarts at address 0.
  - Simultaneous: in IDLE/FILL a word accepted on the last-word cycle is written and the FSM still leaves FILL that edge.
  - Reset mid-operation: immediate return to IDLE with all outputs 0; partial RAM contents are left as is and the next job overwrites them from 0.

Optional Feature:
- Macro: LOADER_LAST_EN.
- Defined: adds output port out_last (1 bit, reset 0). out_last=1 together with out_valid on the final result of a job (rcnt==N_PAIRS-1), and follows out_valid/out_data stability rules.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset hold: rst=1 mid-FILL (after 5 words) -> all outputs 0, busy=0. Next job writes word 0 to iram_addr 0.
- Full fill, N_PAIRS=8: 16 back-to-back words 0x0001..0x0010 -> iram_we on 16 consecutive cycles, addresses 0..15 matching data. core_start is a single-cycle pulse on the cycle after word 16.
- Stalled fill: in_valid toggled 1/0 -> writes only on in_valid=1 cycles, addresses contiguous. in_valid=1 during WAIT_DONE -> in_ready=0, no iram_we.
- Drain, out_ready=1 always: core_done pulse, output RAM holds 0xA0000000+i -> 8 results in order, each 3 cycles apart. busy drops after the 8th.
- Backpressure: out_ready=0 for 4 cycles on result 3 -> out_valid=1 and out_data constant throughout, no rcnt advance. Result 4 follows after release.
- LOADER_LAST_EN defined: out_last=1 only with result 7; undefined build compiles without the port.
